// File: rtl/dmem_if.sv
// Load/store request and response channels between the memory-stage initiator
// and the data-memory responder. The initiator uses the master modport and the
// responder uses the slave modport.
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder for the memory-stage load/store port.
// It accepts one request at a time and waits WAIT_CYCLES clocks. It then
// performs a byte, half or word access on an internal word array. The result
// is returned over a valid/ready response channel.
// Optional feature: define DMEM_MISALIGN_ERR_EN to flag misaligned half and
// word accesses as errors. When it is undefined, the low address bits below
// the access size are ignored.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input  logic  clk,
  input  logic  rst,
  dmem_if.slave bus,
  output logic  busy
);
  localparam int unsigned AW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [33:0] SPAN = 34'(DEPTH_WORDS) * 34'd4;

  if (WAIT_CYCLES > 15) begin : g_wait_range
    $error("dmem_responder: WAIT_CYCLES must be in 0..15");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;

  logic        l_we;
  logic [31:0] l_addr;
  logic [31:0] l_wdata;
  logic [1:0]  l_size;
  logic        l_uns;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0] off;
  logic        in_range;
  logic        misal;
  logic        acc_err;
  logic [AW-1:0] idx;
  logic [3:0]  be;
  logic [31:0] wword;
  logic [31:0] rword;
  logic [31:0] rshift;
  logic [31:0] ldata;
  logic        access;
  logic        do_write;

  // The access happens on the edge that leaves WAIT with the counter at zero.
  assign access   = (state == ST_WAIT) && (cnt == 4'd0);
  assign do_write = access && l_we && !acc_err;

  // Decode the latched request: range, size and alignment checks, lane enables and load extension.
  always_comb begin
    off      = l_addr - ADDR_BASE;
    in_range = ({2'b00, off} < SPAN);
`ifdef DMEM_MISALIGN_ERR_EN
    misal    = ((l_size == 2'b01) && l_addr[0]) ||
               ((l_size == 2'b10) && (l_addr[1:0] != 2'b00));
`else
    misal    = 1'b0;
`endif
    acc_err  = !in_range || (l_size == 2'b11) || misal;
    idx      = off[AW+1:2];
    rword    = mem[idx];
    be       = 4'b1111;
    wword    = l_wdata;
    rshift   = rword;
    ldata    = rword;
    case (l_size)
      2'b00: begin
        be     = 4'b0001 << l_addr[1:0];
        wword  = {4{l_wdata[7:0]}};
        rshift = rword >> {l_addr[1:0], 3'b000};
        ldata  = l_uns ? {24'h0, rshift[7:0]} : {{24{rshift[7]}}, rshift[7:0]};
      end
      2'b01: begin
        be     = l_addr[1] ? 4'b1100 : 4'b0011;
        wword  = {2{l_wdata[15:0]}};
        rshift = rword >> {l_addr[1], 4'b0000};
        ldata  = l_uns ? {16'h0, rshift[15:0]} : {{16{rshift[15]}}, rshift[15:0]};
      end
      default: begin
        be     = 4'b1111;
        wword  = l_wdata;
        rshift = rword;
        ldata  = rword;
      end
    endcase
  end

  // Capture the request fields at acceptance; these are data and are never reset.
  always_ff @(posedge clk) begin
    if ((state == ST_IDLE) && bus.req_valid) begin
      l_we    <= bus.req_we;
      l_addr  <= bus.req_addr;
      l_wdata <= bus.req_wdata;
      l_size  <= bus.req_size;
      l_uns   <= bus.req_unsigned;
    end
  end

  // Commit store lanes into the array. The array has no reset, and a reset during WAIT drops the store.
  always_ff @(posedge clk) begin
    if (do_write && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  // Handshake FSM with registered ready, busy and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      cnt           <= 4'd0;
      bus.req_ready <= 1'b1;
      busy          <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= 32'h0;
      bus.rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            state         <= ST_WAIT;
            cnt           <= 4'(WAIT_CYCLES);
            bus.req_ready <= 1'b0;
            busy          <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            state         <= ST_RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= acc_err;
            bus.rsp_rdata <= (acc_err || l_we) ? 32'h0 : ldata;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            state         <= ST_IDLE;
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            busy          <= 1'b0;
          end
        end
        default: begin
          state         <= ST_IDLE;
          bus.req_ready <= 1'b1;
          busy          <= 1'b0;
          bus.rsp_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule
